// File: rtl/apb_slave_mem.sv
// ============================================================================
// apb_slave_mem: APB slave with byte-strobed word memory and fixed wait states.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int                  LSB        = $clog2(STRB_WIDTH);
  localparam int                  IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [3:0]          WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state;
  state_t                  phase;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic                    ready_q;
  logic                    slverr_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0]   src_addr;
  logic                    src_write;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [IDX_W-1:0]        mem_idx;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rd_val;

  // The setup phase is the bus cycle itself, so it is decoded from the live
  // bus; the registered state only needs to remember IDLE versus ACCESS.
  always_comb begin
    phase = state;
    if (state == IDLE && PSEL && !PENABLE) phase = SETUP;
    src_addr  = (phase == SETUP) ? PADDR  : addr_q;
    src_write = (phase == SETUP) ? PWRITE : write_q;
    word_idx  = src_addr >> LSB;
    mem_idx   = word_idx[IDX_W-1:0];
    err       = ({1'b0, word_idx} >= DEPTH_LIM) || (|(src_addr & ALIGN_MASK));
    rd_val    = (!src_write && !err) ? mem[mem_idx] : '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
      case (phase)
        SETUP: begin
          state   <= ACCESS;
          addr_q  <= PADDR;
          write_q <= PWRITE;
          wdata_q <= PWDATA;
          strb_q  <= PSTRB;
          cnt     <= WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            ready_q  <= 1'b1;
            slverr_q <= err;
            rdata_q  <= rd_val;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (ready_q) begin
            state <= IDLE;
            if (write_q && !err) begin
              for (int i = 0; i < STRB_WIDTH; i++)
                if (strb_q[i]) mem[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
          end else begin
            cnt <= cnt - 4'd1;
            // Response is registered on the edge that enters the final cycle.
            if (cnt == 4'd1) begin
              ready_q  <= 1'b1;
              slverr_q <= err;
              rdata_q  <= rd_val;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign PREADY  = ready_q;
  assign PSLVERR = slverr_q;
  assign PRDATA  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// ============================================================================
// tb_apb_slave_mem: self-checking bench driving three slaves (0, 3, 2 waits).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [8:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_slave_mem #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) dut_w0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_slave_mem #(.WAIT_CYCLES(3)) dut_w3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr[7:0]), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_slave_mem #(.WAIT_CYCLES(2)) dut_w2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr[7:0]), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
    int          waits;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_xfer(input string name, input logic [31:0] rd, input logic err, input int waits);
    exp_t e;
    e.name = name; e.rd = rd; e.err = err; e.waits = waits;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the completing edge so
  // that a following call forms a back-to-back transfer.
  task automatic xfer(input int d, input bit wr, input logic [8:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input bit scramble);
    exp_t e;
    int   waits;
    bit   done;
    psel = 3'b000; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (pready[d]) begin
        done = 1'b1;
        e = sb.pop_front();
        check({e.name, ".rdata"}, prdata[d], e.rd);
        check({e.name, ".slverr"}, 32'(pslverr[d]), 32'(e.err));
        check({e.name, ".waits"}, 32'(waits), 32'(e.waits));
      end else begin
        waits++;
        if (scramble) begin
          paddr = 9'($urandom); pwdata = $urandom; pstrb = 4'($urandom); pwrite = ~wr;
        end
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      e = sb.pop_front();
      tests++; fails++;
      $display("FAIL %s.timeout: PREADY still 0 after 40 cycles, expected 1", e.name);
    end
    psel = 3'b000; penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vecs[0]  = '{1'b1, 9'h004, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 9'h004, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 9'h008, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, 9'h008, 32'h11223344, 4'h5, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, 9'h008, 32'h00000000, 4'h0, 32'hFF22FF44, 1'b0};
    vecs[5]  = '{1'b1, 9'h100, 32'h12345678, 4'hF, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b1, 9'h002, 32'hAAAAAAAA, 4'hF, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 9'h100, 32'h00000000, 4'h0, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b0, 9'h000, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 9'h004, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b1, 9'h00C, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0};
    vecs[11] = '{1'b1, 9'h00C, 32'hFFFFFFFF, 4'h0, 32'h00000000, 1'b0};
    vecs[12] = '{1'b0, 9'h00C, 32'h00000000, 4'h0, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b1, 9'h0FC, 32'h5A5A5A5A, 4'h3, 32'h00000000, 1'b0};
    vecs[14] = '{1'b0, 9'h0FC, 32'h00000000, 4'h0, 32'h00005A5A, 1'b0};
    vecs[15] = '{1'b0, 9'h003, 32'h00000000, 4'h0, 32'h00000000, 1'b1};
    vecs[16] = '{1'b0, 9'h1FC, 32'h00000000, 4'h0, 32'h00000000, 1'b1};

    rst_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst%0d.pready", d), 32'(pready[d]), 32'd0);
      check($sformatf("rst%0d.pslverr", d), 32'(pslverr[d]), 32'd0);
      check($sformatf("rst%0d.prdata", d), prdata[d], 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("post_rst%0d.pready", d), 32'(pready[d]), 32'd0);
      check($sformatf("post_rst%0d.prdata", d), prdata[d], 32'd0);
    end
    @(posedge clk); #1;

    // Zero-wait slave: whole table back-to-back
    c0 = cyc;
    for (int i = 0; i < NV; i++) begin
      expect_xfer($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_err, 0);
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 1'b0);
    end
    check("b2b_cycles", 32'(cyc - c0), 32'(2 * NV));

    // Three-wait slave, including bus scrambling during wait states
    expect_xfer("w3_rd00", 32'h0, 1'b0, 3);          xfer(1, 1'b0, 9'h000, 32'h0, 4'h0, 1'b0);
    expect_xfer("w3_wr10", 32'h0, 1'b0, 3);          xfer(1, 1'b1, 9'h010, 32'h01020304, 4'hF, 1'b0);
    expect_xfer("w3_rd10", 32'h01020304, 1'b0, 3);   xfer(1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0);
    expect_xfer("w3_wr14_scr", 32'h0, 1'b0, 3);      xfer(1, 1'b1, 9'h014, 32'h00000077, 4'hF, 1'b1);
    expect_xfer("w3_rd14", 32'h00000077, 1'b0, 3);   xfer(1, 1'b0, 9'h014, 32'h0, 4'h0, 1'b0);
    expect_xfer("w3_rd18", 32'h0, 1'b0, 3);          xfer(1, 1'b0, 9'h018, 32'h0, 4'h0, 1'b0);
    expect_xfer("w3_err06", 32'h0, 1'b1, 3);         xfer(1, 1'b0, 9'h006, 32'h0, 4'h0, 1'b0);

    // Two-wait slave: abort in the second ACCESS cycle
    expect_xfer("w2_wr0c", 32'h0, 1'b0, 2);          xfer(2, 1'b1, 9'h00C, 32'h11111111, 4'hF, 1'b0);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 9'h00C; pwdata = 32'h22222222; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk); check("abort.acc1_pready", 32'(pready[2]), 32'd0);
    @(posedge clk); #1; psel = 3'b000; penable = 1'b0;
    @(negedge clk); check("abort.acc2_pready", 32'(pready[2]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("abort.idle_pready", 32'(pready[2]), 32'd0);
    @(posedge clk); #1;
    expect_xfer("w2_rd0c_abort", 32'h11111111, 1'b0, 2); xfer(2, 1'b0, 9'h00C, 32'h0, 4'h0, 1'b0);

    // Missing setup phase is ignored
    psel = 3'b100; penable = 1'b1; pwrite = 1'b1; paddr = 9'h00C; pwdata = 32'h33333333; pstrb = 4'hF;
    repeat (3) begin
      @(negedge clk); check("nosetup.pready", 32'(pready[2]), 32'd0);
    end
    @(posedge clk); #1; psel = 3'b000; penable = 1'b0;
    expect_xfer("w2_rd0c_nosetup", 32'h11111111, 1'b0, 2); xfer(2, 1'b0, 9'h00C, 32'h0, 4'h0, 1'b0);

    // Reset during a wait state, then every location reads zero
    psel = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 9'h010;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("rst_wait.pready", 32'(pready[1]), 32'd0);
    check("rst_wait.pslverr", 32'(pslverr[1]), 32'd0);
    check("rst_wait.prdata", prdata[1], 32'd0);
    psel = 3'b000; penable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      expect_xfer($sformatf("sweep%0d", i), 32'h0, 1'b0, 0);
      xfer(0, 1'b0, 9'(i * 4), 32'h0, 4'h0, 1'b0);
    end
    expect_xfer("w3_rd10_post_rst", 32'h0, 1'b0, 3); xfer(1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0);
    expect_xfer("w3_rd14_post_rst", 32'h0, 1'b0, 3); xfer(1, 1'b0, 9'h014, 32'h0, 4'h0, 1'b0);
    expect_xfer("w2_rd0c_post_rst", 32'h0, 1'b0, 2); xfer(2, 1'b0, 9'h00C, 32'h0, 4'h0, 1'b0);

    // Reset asserted inside a completing read clears outputs asynchronously
    expect_xfer("w0_wr04_again", 32'h0, 1'b0, 0);    xfer(0, 1'b1, 9'h004, 32'hDEADBEEF, 4'hF, 1'b0);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 9'h004;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    check("rst_done.pre_pready", 32'(pready[0]), 32'd1);
    check("rst_done.pre_prdata", prdata[0], 32'hDEADBEEF);
    #1 rst_n = 1'b0; #1;
    check("rst_done.pready", 32'(pready[0]), 32'd0);
    check("rst_done.prdata", prdata[0], 32'd0);
    psel = 3'b000; penable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    expect_xfer("w0_rd04_post_rst", 32'h0, 1'b0, 0); xfer(0, 1'b0, 9'h004, 32'h0, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: PADDR width, byte address.
REQ-002 Parameter DATA_WIDTH, default 32: PWDATA/PRDATA width; legal values 8, 16, 32.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8: PSTRB width, one bit per byte lane.
REQ-004 Parameter MEM_DEPTH, default 64: number of DATA_WIDTH words; SHALL be at most 2^(ADDR_WIDTH-log2(STRB_WIDTH)).
REQ-005 Parameter WAIT_CYCLES, default 0: wait states inserted in every ACCESS phase, range 0-15.
REQ-006 PCLK  input  1  sole clock; all state updates on rising edge.
REQ-007 PRESETn  input  1  reset, asynchronous assert, active-low.
REQ-008 PSEL  input  1  slave select.
REQ-009 PENABLE  input  1  access-phase indicator.
REQ-010 PWRITE  input  1  1 = write, 0 = read.
REQ-011 PADDR  input  ADDR_WIDTH  byte address.
REQ-012 PWDATA  input  DATA_WIDTH  write data.
REQ-013 PSTRB  input  STRB_WIDTH  write byte-lane enables.
REQ-014 PRDATA  output  DATA_WIDTH  read data.
REQ-015 PREADY  output  1  transfer-complete indicator.
REQ-016 PSLVERR  output  1  transfer error, meaningful only while PSEL&PENABLE&PREADY.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS; PSEL&!PENABLE in IDLE or ACCESS-complete -> SETUP; SETUP -> ACCESS unconditionally next edge; ACCESS with PREADY=1 -> SETUP if PSEL&!PENABLE sampled next, else IDLE.
REQ-018 SETUP edge SHALL latch PADDR, PWRITE, PWDATA, PSTRB and load wait counter with WAIT_CYCLES.
REQ-019 In ACCESS, PREADY SHALL be 0 while counter non-zero (counter decrements each edge) and 1 when counter is zero; WAIT_CYCLES=0 gives PREADY=1 in the first ACCESS cycle.
REQ-020 PREADY SHALL be 0 in IDLE and SETUP.
REQ-021 Word index = PADDR[ADDR_WIDTH-1:log2(STRB_WIDTH)]; error when index >= MEM_DEPTH or PADDR low log2(STRB_WIDTH) bits non-zero.
REQ-022 PSLVERR SHALL equal the error condition during the ACCESS cycle with PREADY=1, and 0 in all other cycles.
REQ-023 Write commits at the edge ending an ACCESS cycle with PREADY=1 and no error; only byte lanes with PSTRB[i]=1 update; PSTRB=0 is a legal no-op.
REQ-024 Erroring write SHALL leave memory unchanged.
REQ-025 PRDATA SHALL present mem[index] during read ACCESS cycle with PREADY=1 and no error; 0 otherwise (including errors and writes).
REQ-026 Read data SHALL reflect all writes committed at earlier edges (write at edge N visible to read ACCESS after N).
REQ-027 PSEL deasserted in SETUP or ACCESS before completion: abort, -> IDLE, no write, PREADY=0.
REQ-028 PSEL&PENABLE sampled in IDLE (missing setup): ignored, stay IDLE, no write, PREADY=0.
REQ-029 Address/data/control changes during wait states SHALL be ignored; latched SETUP values are used.
REQ-030 Back-to-back transfers SHALL sustain one transfer per 2+WAIT_CYCLES cycles with no idle cycle.

Reset
REQ-031 PRESETn low SHALL immediately force state IDLE, counter 0, PREADY 0, PSLVERR 0, PRDATA 0, all memory words 0.
REQ-032 Reset mid-transfer SHALL abort without memory update; first transfer after release needs a full SETUP phase.
REQ-033 Outputs SHALL hold reset values until first SETUP after PRESETn rises.

Verification
REQ-034 WAIT_CYCLES=0: write 0xDEADBEEF to 0x04, PSTRB=0xF, then read 0x04 -> PREADY=1 first ACCESS cycle each time, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-035 WAIT_CYCLES=3: read 0x00 after reset -> PREADY low 3 ACCESS cycles, high on 4th, PRDATA=0x00000000.
REQ-036 Write 0xFFFFFFFF to 0x08, then 0x11223344 with PSTRB=0x5 -> read returns 0xFF22FF44.
REQ-037 Write to 0x100 (index 64, MEM_DEPTH=64) and to 0x02 (misaligned) -> PSLVERR=1 with PREADY, memory unchanged, PRDATA=0.
REQ-038 WAIT_CYCLES=2 write to 0x0C, PSEL dropped in 2nd ACCESS cycle -> FSM IDLE, subsequent read 0x0C returns prior value.
REQ-039 PRESETn pulsed low during ACCESS wait -> PREADY/PSLVERR/PRDATA 0 same cycle, all locations read 0 afterwards.
